// File: rtl/audio_pcm_tx_fifo.sv
// audio_pcm_tx_fifo
// Transmit-side PCM sample buffer in front of the I2S controller. Bus/DMA
// words are queued in a circular buffer and presented to the consumer one
// sample per handshake. In pack16 mode each word is split into two 16-bit
// samples, high half first. When the buffer is empty a fill sample is
// substituted, and each starved transfer is counted.

module audio_pcm_tx_fifo #(
  parameter  int DEPTH      = 16,
  parameter  int DATA_WIDTH = 32,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  pack16,
  input  logic                  underrun_mode,
  input  logic [AW:0]           thresh,
  input  logic                  clr_cnt,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] pcm_data,
  output logic                  pcm_valid,
  input  logic                  pcm_ready,
  output logic [AW:0]           level,
  output logic                  req,
  output logic                  underrun,
  output logic [15:0]           underrun_cnt
);

  localparam logic            PHASE_HI = 1'b0;
  localparam logic            PHASE_LO = 1'b1;
  localparam logic [AW:0]     FULL_LVL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]     LVL_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [15:0]     CNT_MAX  = 16'hFFFF;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           level_q, level_d;
  logic                  phase_q, phase_d;
  logic [DATA_WIDTH-1:0] last_sample_q, last_sample_d;
  logic                  underrun_q, underrun_d;
  logic [15:0]           underrun_cnt_q, underrun_cnt_d;

  logic                  empty;
  logic                  full;
  logic [DATA_WIDTH-1:0] head;
  logic                  push;
  logic                  xfer;
  logic                  starved;
  logic                  pop;

  // Outputs toward bus and I2S side: derived only from registered state and
  // the static mode inputs, never from wr_valid or pcm_ready.
  always_comb begin
    empty     = (level_q == '0);
    full      = (level_q == FULL_LVL);
    head      = mem_q[rd_ptr_q];
    wr_ready  = enable && !full;
    pcm_valid = enable;
    req       = enable && (level_q <= thresh);
    pcm_data  = '0;
    if (enable) begin
      if (empty) begin
        pcm_data = underrun_mode ? last_sample_q : '0;
      end else if (!pack16) begin
        pcm_data = head;
      end else if (phase_q == PHASE_HI) begin
        pcm_data = {head[31:16], 16'h0000};
      end else begin
        pcm_data = {head[15:0], 16'h0000};
      end
    end
  end

  // Handshake decode: a starved transfer never pops; in pack16 mode only the
  // low-half transfer retires the head word.
  always_comb begin
    push    = wr_valid && wr_ready;
    xfer    = pcm_valid && pcm_ready;
    starved = xfer && empty;
    pop     = xfer && !empty && (!pack16 || (phase_q == PHASE_LO));
  end

  // Next-state for pointers, level, phase, last sample and underrun flag;
  // dropping enable flushes everything except the underrun counter.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    phase_d       = phase_q;
    last_sample_d = last_sample_q;
    underrun_d    = 1'b0;
    if (!enable) begin
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      level_d       = '0;
      phase_d       = PHASE_HI;
      last_sample_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
      if (!pack16) begin
        phase_d = PHASE_HI;
      end else if (xfer && !empty) begin
        phase_d = (phase_q == PHASE_HI) ? PHASE_LO : PHASE_HI;
      end
      if (xfer && !empty) begin
        last_sample_d = pcm_data;
      end
      underrun_d = starved;
    end
  end

  // Saturating underrun counter; a clear wins over a same-cycle increment.
  always_comb begin
    underrun_cnt_d = underrun_cnt_q;
    if (clr_cnt) begin
      underrun_cnt_d = '0;
    end else if (starved && (underrun_cnt_q != CNT_MAX)) begin
      underrun_cnt_d = underrun_cnt_q + 16'd1;
    end
  end

  // Sample storage; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Control state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      phase_q        <= PHASE_HI;
      last_sample_q  <= '0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      phase_q        <= phase_d;
      last_sample_q  <= last_sample_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign level        = level_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_audio_pcm_tx_fifo.sv
// tb_audio_pcm_tx_fifo
// Directed bench for audio_pcm_tx_fifo (DEPTH=16). Inputs change 1 time unit
// after a rising edge; outputs are checked at that same point, away from
// the edge.

module tb_audio_pcm_tx_fifo;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        pack16;
  logic        underrun_mode;
  logic [4:0]  thresh;
  logic        clr_cnt;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] pcm_data;
  logic        pcm_valid;
  logic        pcm_ready;
  logic [4:0]  level;
  logic        req;
  logic        underrun;
  logic [15:0] underrun_cnt;

  int tests_run;
  int tests_failed;

  audio_pcm_tx_fifo #(.DEPTH(16), .DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .pack16       (pack16),
    .underrun_mode(underrun_mode),
    .thresh       (thresh),
    .clr_cnt      (clr_cnt),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .pcm_data     (pcm_data),
    .pcm_valid    (pcm_valid),
    .pcm_ready    (pcm_ready),
    .level        (level),
    .req          (req),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and on mismatch reports tag/observed/expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive the handshake inputs, then let one clock edge pass.
  task automatic applyStimulus(input logic wv, input logic [31:0] wd, input logic pr);
    wr_valid  = wv;
    wr_data   = wd;
    pcm_ready = pr;
    @(posedge clk);
    #1;
  endtask

  // Linear directed test sequence.
  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    rst_n         = 1'b0;
    enable        = 1'b0;
    pack16        = 1'b0;
    underrun_mode = 1'b0;
    thresh        = 5'd4;
    clr_cnt       = 1'b0;
    wr_data       = '0;
    wr_valid      = 1'b0;
    pcm_ready     = 1'b0;

    // Reset values
    #12;
    checkOutput("rst_wr_ready", 32'(wr_ready), 32'd0);
    checkOutput("rst_pcm_valid", 32'(pcm_valid), 32'd0);
    checkOutput("rst_pcm_data", pcm_data, 32'h0);
    checkOutput("rst_level", 32'(level), 32'd0);
    checkOutput("rst_req", 32'(req), 32'd0);
    checkOutput("rst_underrun", 32'(underrun), 32'd0);
    checkOutput("rst_cnt", 32'(underrun_cnt), 32'd0);
    #1 rst_n = 1'b1;

    // Plain words: three writes, three transfers
    enable = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("en_pcm_valid", 32'(pcm_valid), 32'd1);
    checkOutput("en_wr_ready", 32'(wr_ready), 32'd1);
    applyStimulus(1'b1, 32'h11111111, 1'b0);
    checkOutput("t1_first_visible", pcm_data, 32'h11111111);
    checkOutput("t1_level1", 32'(level), 32'd1);
    applyStimulus(1'b1, 32'h22222222, 1'b0);
    applyStimulus(1'b1, 32'h33333333, 1'b0);
    checkOutput("t1_level3", 32'(level), 32'd3);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t1_data2", pcm_data, 32'h22222222);
    checkOutput("t1_level2", 32'(level), 32'd2);
    checkOutput("t1_no_underrun_a", 32'(underrun), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t1_data3", pcm_data, 32'h33333333);
    checkOutput("t1_level1b", 32'(level), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t1_level0", 32'(level), 32'd0);
    checkOutput("t1_fill_zero", pcm_data, 32'h0);
    checkOutput("t1_no_underrun_b", 32'(underrun), 32'd0);

    // pack16 unpacking, hi half first
    enable = 1'b0;
    pack16 = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    enable = 1'b1;
    applyStimulus(1'b1, 32'hAAAA5555, 1'b0);
    checkOutput("p16_hi", pcm_data, 32'hAAAA0000);
    checkOutput("p16_level1", 32'(level), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("p16_lo", pcm_data, 32'h55550000);
    checkOutput("p16_level1_after_hi", 32'(level), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("p16_level0", 32'(level), 32'd0);
    checkOutput("p16_no_underrun", 32'(underrun), 32'd0);

    // Repeat-last underrun and counter clear
    enable = 1'b0;
    pack16 = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0);
    enable = 1'b1;
    applyStimulus(1'b1, 32'h12345678, 1'b0);
    checkOutput("ur_head", pcm_data, 32'h12345678);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("ur_drained", 32'(level), 32'd0);
    underrun_mode = 1'b1;
    #1;
    checkOutput("ur_repeat_comb", pcm_data, 32'h12345678);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("ur_pulse", 32'(underrun), 32'd1);
      checkOutput("ur_cnt", 32'(underrun_cnt), 32'(i));
      checkOutput("ur_repeat", pcm_data, 32'h12345678);
    end
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("ur_pulse_end", 32'(underrun), 32'd0);
    checkOutput("ur_cnt_hold", 32'(underrun_cnt), 32'd3);
    clr_cnt = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("clr_cnt", 32'(underrun_cnt), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("clr_prio_pulse", 32'(underrun), 32'd1);
    checkOutput("clr_prio_cnt", 32'(underrun_cnt), 32'd0);
    clr_cnt = 1'b0;
    underrun_mode = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0);

    // Fill to full, blocked 17th write, pop at full, push+pop mid-level
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 32'h100 + 32'(i), 1'b0);
    end
    checkOutput("full_level", 32'(level), 32'd16);
    checkOutput("full_wr_ready", 32'(wr_ready), 32'd0);
    checkOutput("full_req", 32'(req), 32'd0);
    checkOutput("full_head", pcm_data, 32'h101);
    applyStimulus(1'b1, 32'h111, 1'b0);
    checkOutput("full_blocked", 32'(level), 32'd16);
    applyStimulus(1'b1, 32'h111, 1'b1);
    checkOutput("full_pop_level", 32'(level), 32'd15);
    checkOutput("full_pop_data", pcm_data, 32'h102);
    checkOutput("full_pop_ready", 32'(wr_ready), 32'd1);
    applyStimulus(1'b1, 32'h200, 1'b1);
    checkOutput("pushpop_level", 32'(level), 32'd15);
    checkOutput("pushpop_data", pcm_data, 32'h103);
    for (int i = 3; i <= 16; i++) begin
      checkOutput("drain_data", pcm_data, 32'h100 + 32'(i));
      applyStimulus(1'b0, 32'h0, 1'b1);
    end
    checkOutput("drain_last", pcm_data, 32'h200);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("drain_level0", 32'(level), 32'd0);
    checkOutput("drain_no_underrun", 32'(underrun), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0);

    // Refill request against thresh=4
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 32'h300 + 32'(i), 1'b0);
    end
    for (int lvl = 6; lvl >= 0; lvl--) begin
      checkOutput("req_level", 32'(level), 32'(lvl));
      checkOutput("req_value", 32'(req), (lvl <= 4) ? 32'd1 : 32'd0);
      if (lvl > 0) begin
        applyStimulus(1'b0, 32'h0, 1'b1);
      end
    end

    // Flush via enable; counter survives, no underrun while disabled
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("pre_flush_cnt", 32'(underrun_cnt), 32'd1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'h400 + 32'(i), 1'b0);
    end
    checkOutput("pre_flush_level", 32'(level), 32'd5);
    enable = 1'b0;
    #1;
    checkOutput("dis_wr_ready", 32'(wr_ready), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("flush_level", 32'(level), 32'd0);
    checkOutput("flush_req", 32'(req), 32'd0);
    checkOutput("flush_pcm_valid", 32'(pcm_valid), 32'd0);
    checkOutput("flush_pcm_data", pcm_data, 32'h0);
    checkOutput("flush_no_underrun", 32'(underrun), 32'd0);
    checkOutput("flush_cnt", 32'(underrun_cnt), 32'd1);
    enable = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("reen_data", pcm_data, 32'h0);
    checkOutput("reen_valid", 32'(pcm_valid), 32'd1);
    checkOutput("reen_req", 32'(req), 32'd1);
    underrun_mode = 1'b1;
    #1;
    checkOutput("reen_last_cleared", pcm_data, 32'h0);
    underrun_mode = 1'b0;

    // Push into empty FIFO while a transfer starves in the same cycle
    applyStimulus(1'b1, 32'hCAFE0001, 1'b1);
    checkOutput("starve_push_level", 32'(level), 32'd1);
    checkOutput("starve_push_pulse", 32'(underrun), 32'd1);
    checkOutput("starve_push_cnt", 32'(underrun_cnt), 32'd2);
    checkOutput("starve_push_data", pcm_data, 32'hCAFE0001);
    applyStimulus(1'b0, 32'h0, 1'b0);

    // Asynchronous reset mid-operation
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_level", 32'(level), 32'd0);
    checkOutput("async_rst_cnt", 32'(underrun_cnt), 32'd0);
    checkOutput("async_rst_valid", 32'(pcm_valid), 32'd1);
    checkOutput("async_rst_data", pcm_data, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
